// File: rtl/linear_ctrl_pkg.sv
// Shared types and address-width helpers for the linear layer scheduler.
package linear_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FINAL,
        ST_OUTPUT
    } state_t;

    // Address widths never drop below one bit, so single-entry buffers still get a real port.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int CHUNK_W = addr_width(4);
    localparam int WADDR_W = addr_width(16 * 4);
    localparam int NEUR_W  = addr_width(16);

endpackage

// File: rtl/linear_layer_scheduler.sv
// Sequences one fully-connected layer through the shared vector multiplier,
// one output neuron at a time, and streams the corrected results downstream.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | one feature/weight chunk address per cycle
// DRAIN  | waiting for the last two partial sums to arrive
// FINAL  | apply bias and weight zero-point correction
// OUTPUT | result presented until the downstream accepts it
module linear_layer_scheduler
    import linear_ctrl_pkg::*;
#(
    parameter int PRECISION      = 8,
    parameter int BIAS_PRECISION = 32,
    parameter int NUM_CHUNKS     = 4,
    parameter int NUM_NEURONS    = 16,
    localparam int CHUNK_AW      = addr_width(NUM_CHUNKS),
    localparam int WADDR_AW      = addr_width(NUM_NEURONS * NUM_CHUNKS),
    localparam int NEUR_AW       = addr_width(NUM_NEURONS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [CHUNK_AW-1:0]       feat_addr,
    output logic [WADDR_AW-1:0]       wgt_addr,
    output logic [NEUR_AW-1:0]        bias_addr,
    output logic                      mult_ce,
    input  logic [BIAS_PRECISION-1:0] mult_acc,
    input  logic [BIAS_PRECISION-1:0] mult_ai,
    input  logic [BIAS_PRECISION-1:0] bias_in,
    input  logic [PRECISION-1:0]      w_zp,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BIAS_PRECISION-1:0] out_data,
    output logic [NEUR_AW-1:0]        out_index
);

    state_t                    state, state_nxt;
    logic [CHUNK_AW-1:0]       chunk;
    logic [NEUR_AW-1:0]        neuron;
    logic [1:0]                valid_pipe;
    logic [BIAS_PRECISION-1:0] sum_acc, sum_ai;
    logic                      last_chunk, last_neuron, handshake;
    logic [BIAS_PRECISION-1:0] zp_ext, zp_corr, result;

    assign last_chunk  = (chunk == CHUNK_AW'(NUM_CHUNKS - 1));
    assign last_neuron = (neuron == NEUR_AW'(NUM_NEURONS - 1));
    assign handshake   = (state == ST_OUTPUT) && out_ready;

    // Zero point is unsigned; the product wraps at the accumulator width.
    assign zp_ext  = BIAS_PRECISION'(w_zp);
    assign zp_corr = zp_ext * sum_ai;
    assign result  = sum_acc + bias_in - zp_corr;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_ISSUE;
            ST_ISSUE:  if (last_chunk) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!valid_pipe[0]) state_nxt = ST_FINAL;
            ST_FINAL:  state_nxt = ST_OUTPUT;
            ST_OUTPUT: if (out_ready) state_nxt = last_neuron ? ST_IDLE : ST_ISSUE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        out_valid = (state == ST_OUTPUT);
        mult_ce   = valid_pipe[0];
        bias_addr = neuron;
        feat_addr = '0;
        wgt_addr  = '0;
        if (state == ST_ISSUE) begin
            feat_addr = chunk;
            wgt_addr  = WADDR_AW'(neuron) * WADDR_AW'(NUM_CHUNKS) + WADDR_AW'(chunk);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chunk      <= '0;
            neuron     <= '0;
            valid_pipe <= '0;
            sum_acc    <= '0;
            sum_ai     <= '0;
            out_data   <= '0;
            out_index  <= '0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            valid_pipe <= {valid_pipe[0], state == ST_ISSUE};
            // Multiplier output is only meaningful two cycles after its address went out.
            if (valid_pipe[1]) begin
                sum_acc <= sum_acc + mult_acc;
                sum_ai  <= sum_ai + mult_ai;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        chunk   <= '0;
                        neuron  <= '0;
                        sum_acc <= '0;
                        sum_ai  <= '0;
                    end
                end
                ST_ISSUE: begin
                    chunk <= last_chunk ? '0 : chunk + CHUNK_AW'(1);
                end
                ST_FINAL: begin
                    out_data  <= result;
                    out_index <= neuron;
                end
                ST_OUTPUT: begin
                    if (handshake) begin
                        chunk   <= '0;
                        sum_acc <= '0;
                        sum_ai  <= '0;
                        if (last_neuron) begin
                            neuron <= '0;
                            done   <= 1'b1;
                        end else begin
                            neuron <= neuron + NEUR_AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
